// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetch sequencer for the 16-bit instruction register. Owns the program
//   counter and reads one instruction as two consecutive bytes from byte-wide,
//   combinational-read program memory: the low byte from PC, then the high
//   byte from PC+1. It drives the IR byte-load strobes and pulses FetchDone
//   once both bytes are in the IR.
//
// Optional feature macro:
//   FETCH_WAIT_EN - adds the MemReady input. Each byte phase holds, with PC
//                   frozen and IRWrite low, until MemReady is sampled high.
//
// Handshake:
//   FetchReq is a level request, sampled only while idle. A fetch cannot be
//   aborted except by Reset. PCLoad is honoured only while idle and takes
//   priority over FetchReq in the same cycle.
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   asynchronous, active-high reset
//   FetchReq    in   request one instruction fetch
//   PCLoad      in   load PC from PCIn (idle only)
//   PCIn        in   new PC value
//   MemReady    in   memory byte valid (FETCH_WAIT_EN builds only)
//   MemAddr     out  program memory byte address (always equals PCOut)
//   MemRead     out  memory read strobe
//   IRWrite     out  instruction register write enable
//   IRLH        out  instruction register byte select (0 = low, 1 = high)
//   PCOut       out  current PC
//   Busy        out  fetch in progress
//   FetchDone   out  one-cycle pulse: IR holds a complete instruction
//   DebugState  out  FSM state register, for observation only
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  FetchReq,
    input  logic                  PCLoad,
    input  logic [ADDR_WIDTH-1:0] PCIn,
`ifdef FETCH_WAIT_EN
    input  logic                  MemReady,
`endif
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRead,
    output logic                  IRWrite,
    output logic                  IRLH,
    output logic [ADDR_WIDTH-1:0] PCOut,
    output logic                  Busy,
    output logic                  FetchDone,
    output logic [1:0]            DebugState
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  byte_ok;
    logic                  in_byte_phase;

    // A byte phase completes when memory has the byte on its data output.
`ifdef FETCH_WAIT_EN
    assign byte_ok = MemReady;
`else
    assign byte_ok = 1'b1;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            S_IDLE: begin
                if (PCLoad) begin
                    pc_next = PCIn;
                end else if (FetchReq) begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (byte_ok) begin
                    pc_next    = pc + PC_STEP;
                    state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (byte_ok) begin
                    pc_next    = pc + PC_STEP;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode from state and PC only. In wait builds IRWrite also
    // follows MemReady so the IR never captures a byte that is not valid yet.
    assign in_byte_phase = (state == S_LOW) || (state == S_HIGH);

    assign MemAddr    = pc;
    assign PCOut      = pc;
    assign MemRead    = in_byte_phase;
    assign IRWrite    = in_byte_phase && byte_ok;
    assign IRLH       = (state == S_HIGH);
    assign Busy       = (state != S_IDLE);
    assign FetchDone  = (state == S_DONE);
    assign DebugState = state;

endmodule
